// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory port and its write buffer.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_BUSY = 2'd1,
    RD_BUSY = 2'd2,
    RD_DONE = 2'd3
  } dmem_state_t;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
  } wbuf_entry_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return (addr_lsb & WORD_ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Posted-store circular FIFO with registered occupancy flags and a parallel
// youngest-match lookup over every valid entry, including the in-flight head.
module wbuf_fifo
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        push,
  input  wbuf_entry_t push_entry,
  input  logic        pop,
  output wbuf_entry_t head,
  input  logic [29:0] lookup_waddr,
  output logic        hit,
  output logic [31:0] hit_data,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wbuf_entry_t      entry_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [PTR_W-1:0] lk_idx_s;
  logic             lk_match_s;

  assign push_ok_s = push & ~full_r;
  assign pop_ok_s  = pop & ~empty_r;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_nxt_s = count_r + CNT_W'(1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_nxt_s = count_r - CNT_W'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Storage, pointers and registered flags.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= {62{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        entry_r[wr_ptr_r] <= push_entry;
        wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_W'(DEPTH));
      empty_r <= (count_nxt_s == {CNT_W{1'b0}});
    end
  end

  // Walk oldest to youngest so the youngest matching store overrides older ones.
  always_comb begin
    hit        = 1'b0;
    hit_data   = 32'h0000_0000;
    lk_idx_s   = rd_ptr_r;
    lk_match_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      lk_idx_s   = rd_ptr_r + PTR_W'(k);
      lk_match_s = (CNT_W'(k) < count_r) && (entry_r[lk_idx_s].waddr == lookup_waddr);
      hit        = hit | lk_match_s;
      hit_data   = lk_match_s ? entry_r[lk_idx_s].data : hit_data;
    end
  end

  assign head  = entry_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/dmem_port.sv
// MEM-stage data-memory port: posted write buffer with store-to-load forwarding,
// single-outstanding req/ack memory sequencing and pipeline stall generation.
module dmem_port
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_wmem_i,
  input  logic        mem_read_i,
  input  logic [31:0] addr_i32,
  input  logic [31:0] wdata_i32,
  output logic [31:0] rdata_o32,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        wbuf_empty_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o32,
  output logic [31:0] mem_wdata_o32,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i32
);

  dmem_state_t state_r;
  dmem_state_t state_nxt_s;
  logic [31:0] rd_q_r;
  logic        misalign_r;

  logic        access_s;
  logic        misalign_s;
  logic        store_s;
  logic        load_s;
  logic        load_miss_s;
  logic        push_s;
  logic        pop_s;
  wbuf_entry_t push_entry_s;
  wbuf_entry_t head_s;
  logic        hit_s;
  logic [31:0] hit_data_s;
  logic        full_s;
  logic        empty_s;

  // A simultaneous store and load is treated as the store alone.
  assign access_s     = enable_wmem_i | mem_read_i;
  assign misalign_s   = access_s & is_misaligned(addr_i32[1:0]);
  assign store_s      = enable_wmem_i & ~misalign_s;
  assign load_s       = mem_read_i & ~enable_wmem_i & ~misalign_s;
  assign load_miss_s  = load_s & ~hit_s;
  assign push_s       = store_s & ~full_s;
  assign pop_s        = (state_r == WR_BUSY) & mem_ack_i;
  assign push_entry_s = {addr_i32[31:2], wdata_i32};

  wbuf_fifo #(
    .DEPTH(DEPTH)
  ) u_wbuf (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .push         (push_s),
    .push_entry   (push_entry_s),
    .pop          (pop_s),
    .head         (head_s),
    .lookup_waddr (addr_i32[31:2]),
    .hit          (hit_s),
    .hit_data     (hit_data_s),
    .full         (full_s),
    .empty        (empty_s)
  );

  // Next state: a pending load miss outranks draining the buffer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_miss_s) begin
          state_nxt_s = RD_BUSY;
        end else if (!empty_s) begin
          state_nxt_s = WR_BUSY;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR_BUSY: state_nxt_s = mem_ack_i ? IDLE : WR_BUSY;
      RD_BUSY: state_nxt_s = mem_ack_i ? RD_DONE : RD_BUSY;
      RD_DONE: state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Memory request fields and pipeline-facing stall/data.
  always_comb begin
    stall_o       = 1'b0;
    rdata_o32     = 32'h0000_0000;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o32  = 32'h0000_0000;
    mem_wdata_o32 = 32'h0000_0000;
    case (state_r)
      WR_BUSY: begin
        mem_req_o     = 1'b1;
        mem_we_o      = 1'b1;
        mem_addr_o32  = {head_s.waddr, 2'b00};
        mem_wdata_o32 = head_s.data;
      end
      RD_BUSY: begin
        mem_req_o    = 1'b1;
        mem_we_o     = 1'b0;
        mem_addr_o32 = {addr_i32[31:2], 2'b00};
      end
      default: begin
        mem_req_o = 1'b0;
      end
    endcase
    if (reset_i) begin
      stall_o   = 1'b0;
      rdata_o32 = 32'h0000_0000;
    end else if (load_s && (state_r == RD_DONE)) begin
      stall_o   = 1'b0;
      rdata_o32 = rd_q_r;
    end else if (load_s) begin
      stall_o   = ~hit_s;
      rdata_o32 = hit_s ? hit_data_s : 32'h0000_0000;
    end else if (store_s) begin
      stall_o = full_s;
    end else begin
      stall_o   = 1'b0;
      rdata_o32 = 32'h0000_0000;
    end
  end

  // State register, read-data capture and sticky misalignment flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      rd_q_r     <= 32'h0000_0000;
      misalign_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == RD_BUSY) && mem_ack_i) begin
        rd_q_r <= mem_rdata_i32;
      end
      if (misalign_s) begin
        misalign_r <= 1'b1;
      end
    end
  end

  assign misalign_o   = misalign_r;
  assign wbuf_empty_o = empty_s;

endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port: directed scenarios plus randomized traffic
// against a program-order memory image and an expected write-order queue.
`timescale 1ns/1ps
module tb_dmem_port;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        enable_wmem_i;
  logic        mem_read_i;
  logic [31:0] addr_i32;
  logic [31:0] wdata_i32;
  logic [31:0] rdata_o32;
  logic        stall_o;
  logic        misalign_o;
  logic        wbuf_empty_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o32;
  logic [31:0] mem_wdata_o32;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i32;

  dmem_port #(.DEPTH(4)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .enable_wmem_i (enable_wmem_i),
    .mem_read_i    (mem_read_i),
    .addr_i32      (addr_i32),
    .wdata_i32     (wdata_i32),
    .rdata_o32     (rdata_o32),
    .stall_o       (stall_o),
    .misalign_o    (misalign_o),
    .wbuf_empty_o  (wbuf_empty_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o32  (mem_addr_o32),
    .mem_wdata_o32 (mem_wdata_o32),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i32 (mem_rdata_i32)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Memory contents as seen by the slave, and the program-order view of memory.
  logic [31:0] mem_img [logic [29:0]];
  logic [31:0] ref_img [logic [29:0]];
  logic [61:0] exp_wr_q [$];

  bit  hold_ack  = 1'b0;
  bit  one_shot  = 1'b0;
  int  fixed_lat = 0;
  int  n_rd      = 0;
  int  n_wr      = 0;
  bit  any_mis   = 1'b0;

  bit          s_in_txn   = 1'b0;
  int          s_wait_cnt = 0;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [29:0] s_w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [29:0] w);
    return {w[27:0], 4'h5} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [29:0] w);
    return mem_img.exists(w) ? mem_img[w] : dflt(w);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [29:0] w);
    return ref_img.exists(w) ? ref_img[w] : dflt(w);
  endfunction

  // Memory slave: decides ack for the coming edge on each falling edge.
  initial begin
    mem_ack_i     = 1'b0;
    mem_rdata_i32 = 32'h0;
    forever begin
      @(negedge clk_i);
      if (!mem_req_o) begin
        s_in_txn  = 1'b0;
        mem_ack_i = 1'b0;
      end else begin
        if (s_in_txn && mem_ack_i) begin
          chk("req_gap", 64'(mem_req_o), 64'd0);
          s_in_txn = 1'b0;
        end
        if (!s_in_txn) begin
          s_in_txn   = 1'b1;
          s_we       = mem_we_o;
          s_addr     = mem_addr_o32;
          s_wdata    = mem_wdata_o32;
          s_wait_cnt = (fixed_lat > 0) ? fixed_lat - 1 : int'($urandom_range(3, 0));
          if (mem_we_o) n_wr++;
          else n_rd++;
        end else begin
          chk("req_stable", {31'd0, mem_we_o, mem_addr_o32}, {31'd0, s_we, s_addr});
          chk("req_wdata_stable", 64'(mem_wdata_o32), 64'(s_wdata));
        end
        if (hold_ack && !one_shot) begin
          mem_ack_i = 1'b0;
        end else if (one_shot || s_wait_cnt == 0) begin
          one_shot  = 1'b0;
          mem_ack_i = 1'b1;
          s_w       = mem_addr_o32[31:2];
          if (mem_we_o) begin
            mem_img[s_w] = mem_wdata_o32;
            if (exp_wr_q.size() > 0) begin
              chk("wr_order", {2'b00, s_w, mem_wdata_o32}, {2'b00, exp_wr_q[0]});
              void'(exp_wr_q.pop_front());
            end else begin
              chk("wr_extra", 64'(exp_wr_q.size()), 64'd1);
            end
          end else begin
            mem_rdata_i32 = mem_rd(s_w);
          end
        end else begin
          s_wait_cnt--;
          mem_ack_i = 1'b0;
        end
      end
    end
  end

  // Present one access, wait out the stall, then apply it to the reference model.
  task automatic access(input bit st, input bit ld, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rd);
    bit done = 1'b0;
    int c = 0;
    bit mis;
    mis = (a[1:0] != 2'b00);
    enable_wmem_i = st;
    mem_read_i    = ld;
    addr_i32      = a;
    wdata_i32     = d;
    stalls        = 0;
    while (!done) begin
      @(negedge clk_i);
      if (!stall_o) begin
        done = 1'b1;
      end else if (c >= 200) begin
        chk("acc_timeout", 64'(c), 64'd0);
        done = 1'b1;
      end else begin
        stalls++;
        c++;
      end
    end
    rd = rdata_o32;
    @(posedge clk_i);
    #1;
    enable_wmem_i = 1'b0;
    mem_read_i    = 1'b0;
    if (mis) begin
      any_mis = 1'b1;
      if (ld) chk("mis_rdata", 64'(rd), 64'd0);
    end else if (st) begin
      ref_img[a[31:2]] = d;
      exp_wr_q.push_back({a[31:2], d});
    end else if (ld) begin
      chk("load_data", 64'(rd), 64'(ref_rd(a[31:2])));
    end
  endtask

  task automatic drain();
    int c = 0;
    bit done = 1'b0;
    hold_ack = 1'b0;
    while (!done) begin
      @(negedge clk_i);
      if (wbuf_empty_o && !mem_req_o) done = 1'b1;
      else if (c >= 300) begin
        chk("drain_timeout", 64'(c), 64'd0);
        done = 1'b1;
      end else c++;
    end
    @(posedge clk_i);
    #1;
    chk("drain_q", 64'(exp_wr_q.size()), 64'd0);
  endtask

  initial begin
    int          stalls;
    int          rd0;
    int          r;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;

    reset_i       = 1'b1;
    enable_wmem_i = 1'b0;
    mem_read_i    = 1'b0;
    addr_i32      = 32'h0;
    wdata_i32     = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_req", 64'(mem_req_o), 64'd0);
    chk("rst_we", 64'(mem_we_o), 64'd0);
    chk("rst_addr", 64'(mem_addr_o32), 64'd0);
    chk("rst_wdata", 64'(mem_wdata_o32), 64'd0);
    chk("rst_rdata", 64'(rdata_o32), 64'd0);
    chk("rst_mis", 64'(misalign_o), 64'd0);
    chk("rst_empty", 64'(wbuf_empty_o), 64'd1);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Store then load the same word: forwarded from the buffer, no read issued.
    hold_ack = 1'b1;
    access(1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF, stalls, rd);
    rd0 = n_rd;
    access(1'b0, 1'b1, 32'h100, 32'h0, stalls, rd);
    chk("hit_data", 64'(rd), 64'hDEAD_BEEF);
    chk("hit_stall", 64'(stalls), 64'd0);
    chk("hit_no_rd", 64'(n_rd), 64'(rd0));
    drain();

    // Fill the buffer with ack held off; the fifth store waits for one pop.
    hold_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b0, 32'h500 + 32'(i * 4), 32'h1000 + 32'(i), stalls, rd);
      chk("fill_stall", 64'(stalls), 64'd0);
    end
    enable_wmem_i = 1'b1;
    addr_i32      = 32'h510;
    wdata_i32     = 32'h0000_1004;
    @(negedge clk_i);
    chk("full_stall", 64'(stall_o), 64'd1);
    @(posedge clk_i);
    #1;
    one_shot = 1'b1;
    @(negedge clk_i);
    chk("full_stall_ack", 64'(stall_o), 64'd1);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("full_release", 64'(stall_o), 64'd0);
    @(posedge clk_i);
    #1;
    enable_wmem_i = 1'b0;
    ref_img[30'h144] = 32'h0000_1004;
    exp_wr_q.push_back({30'h144, 32'h0000_1004});
    drain();

    // Load miss with a three-cycle memory.
    mem_img[30'h80] = 32'h1234_5678;
    ref_img[30'h80] = 32'h1234_5678;
    fixed_lat = 3;
    rd0 = n_rd;
    access(1'b0, 1'b1, 32'h200, 32'h0, stalls, rd);
    chk("miss_data", 64'(rd), 64'h1234_5678);
    chk("miss_one_rd", 64'(n_rd - rd0), 64'd1);
    chk("miss_stall_range", 64'((stalls >= 3) && (stalls <= 4)), 64'd1);
    fixed_lat = 0;

    // Two stores to one word then a load: youngest wins, writes retire in order.
    access(1'b1, 1'b0, 32'h40, 32'h1, stalls, rd);
    access(1'b1, 1'b0, 32'h40, 32'h2, stalls, rd);
    access(1'b0, 1'b1, 32'h40, 32'h0, stalls, rd);
    chk("youngest_data", 64'(rd), 64'd2);
    drain();
    chk("youngest_mem", 64'(mem_rd(30'h10)), 64'd2);

    // Misaligned store: dropped without stall, sticky flag.
    access(1'b1, 1'b0, 32'h103, 32'hFFFF_FFFF, stalls, rd);
    chk("mis_stall", 64'(stalls), 64'd0);
    chk("mis_flag", 64'(misalign_o), 64'd1);
    chk("mis_empty", 64'(wbuf_empty_o), 64'd1);
    chk("mis_no_push", 64'(exp_wr_q.size()), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("mis_sticky", 64'(misalign_o), 64'd1);

    // Reset while a write is in flight with three entries buffered.
    hold_ack = 1'b1;
    access(1'b1, 1'b0, 32'h600, 32'hAAAA_0001, stalls, rd);
    access(1'b1, 1'b0, 32'h604, 32'hAAAA_0002, stalls, rd);
    access(1'b1, 1'b0, 32'h608, 32'hAAAA_0003, stalls, rd);
    chk("pre_rst_req", 64'(mem_req_o), 64'd1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("mid_rst_req", 64'(mem_req_o), 64'd0);
    chk("mid_rst_we", 64'(mem_we_o), 64'd0);
    chk("mid_rst_addr", 64'(mem_addr_o32), 64'd0);
    chk("mid_rst_wdata", 64'(mem_wdata_o32), 64'd0);
    chk("mid_rst_stall", 64'(stall_o), 64'd0);
    chk("mid_rst_rdata", 64'(rdata_o32), 64'd0);
    chk("mid_rst_empty", 64'(wbuf_empty_o), 64'd1);
    chk("mid_rst_mis", 64'(misalign_o), 64'd0);
    ref_img.delete();
    foreach (mem_img[k]) ref_img[k] = mem_img[k];
    exp_wr_q.delete();
    any_mis = 1'b0;
    @(posedge clk_i);
    #1;
    reset_i   = 1'b0;
    hold_ack  = 1'b0;
    fixed_lat = 2;
    rd0 = n_rd;
    access(1'b0, 1'b1, 32'h600, 32'h0, stalls, rd);
    chk("post_rst_data", 64'(rd), 64'(dflt(30'h180)));
    chk("post_rst_one_rd", 64'(n_rd - rd0), 64'd1);
    chk("post_rst_stall", 64'(stalls >= 2), 64'd1);
    fixed_lat = 0;

    // Randomized mix of stores, loads and idle cycles over a small address pool.
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(99, 0));
      a = 32'h1000 + 32'($urandom_range(7, 0)) * 32'd4;
      if ($urandom_range(49, 0) == 0) a[1:0] = 2'($urandom_range(3, 1));
      d = $urandom;
      if (r < 45) access(1'b1, 1'b0, a, d, stalls, rd);
      else if (r < 90) access(1'b0, 1'b1, a, 32'h0, stalls, rd);
      else begin
        @(posedge clk_i);
        #1;
      end
    end
    drain();
    chk("final_empty", 64'(wbuf_empty_o), 64'd1);
    chk("final_mis", 64'(misalign_o), 64'(any_mis));
    for (int k = 0; k < 8; k++) begin
      s_w = 30'h400 + 30'(k);
      chk("final_mem", 64'(mem_rd(s_w)), 64'(ref_rd(s_w)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
